// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and counter sizing for the ALU sequencer.
package alu_seq_pkg;

  localparam logic [4:0] OpAnd  = 5'b01010;
  localparam logic [4:0] OpOr   = 5'b01011;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpShr  = 5'b00101;
  localparam logic [4:0] OpShra = 5'b00110;
  localparam logic [4:0] OpShl  = 5'b00111;
  localparam logic [4:0] OpRor  = 5'b01000;
  localparam logic [4:0] OpRol  = 5'b01001;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpNop  = 5'b11010;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  // Wide enough to hold the largest settle count itself, not just count-1.
  function automatic int unsigned cnt_width(input int unsigned mul_cycles,
                                            input int unsigned div_cycles);
    int unsigned m;
    m = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: legality, settle cycles and divide detect.
module alu_op_decode
  import alu_seq_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 4,
  parameter int unsigned CntW       = cnt_width(MUL_CYCLES, DIV_CYCLES)
) (
  input  logic [4:0]      op_i,
  input  logic            incpc_i,
  output logic            legal_o,
  output logic [CntW-1:0] cycles_o,
  output logic            is_div_o
);

  always_comb begin
    legal_o  = 1'b0;
    cycles_o = CntW'(1);
    is_div_o = 1'b0;
    if (incpc_i) begin
      // PC increment ignores the opcode entirely.
      legal_o = 1'b1;
    end else begin
      case (op_i)
        OpAnd, OpOr, OpAdd, OpSub, OpShr, OpShra, OpShl, OpRor, OpRol, OpNeg, OpNot,
        OpNop: legal_o = 1'b1;
        OpMul: begin
          legal_o  = 1'b1;
          cycles_o = CntW'(MUL_CYCLES);
        end
        OpDiv: begin
          legal_o  = 1'b1;
          cycles_o = CntW'(DIV_CYCLES);
          is_div_o = 1'b1;
        end
        default: legal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one request at a time through the shared combinational ALU, holding
// its inputs for a per-opcode settle window, then returns the 64-bit result.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_incpc,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [4:0]  alu_opcode,
  output logic        alu_IncPC,
  input  logic [63:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_err,
  output logic        rsp_dz,
  output logic        busy
);

  localparam int unsigned CntW = cnt_width(MUL_CYCLES, DIV_CYCLES);

  logic            dec_legal;
  logic [CntW-1:0] dec_cycles;
  logic            dec_is_div;

  alu_op_decode #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CntW       (CntW)
  ) u_decode (
    .op_i     (req_op),
    .incpc_i  (req_incpc),
    .legal_o  (dec_legal),
    .cycles_o (dec_cycles),
    .is_div_o (dec_is_div)
  );

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     alu_a_q, alu_b_q;
  logic [4:0]      alu_op_q;
  logic            alu_incpc_q;
  logic            err_pend_q, dz_pend_q;
  logic [31:0]     rsp_hi_q, rsp_lo_q;
  logic            rsp_err_q, rsp_dz_q, rsp_valid_q;
  logic            req_ready_q, busy_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OpNop;
      alu_incpc_q <= 1'b0;
      err_pend_q  <= 1'b0;
      dz_pend_q   <= 1'b0;
      rsp_hi_q    <= '0;
      rsp_lo_q    <= '0;
      rsp_err_q   <= 1'b0;
      rsp_dz_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            state_q     <= StExec;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= dec_cycles - CntW'(1);
            alu_a_q     <= req_a;
            alu_b_q     <= req_b;
            // Illegal ops and PC increments present a nop to the ALU.
            alu_op_q    <= (req_incpc || !dec_legal) ? OpNop : req_op;
            alu_incpc_q <= req_incpc;
            err_pend_q  <= !req_incpc && !dec_legal;
            dz_pend_q   <= dec_is_div && (req_b == '0);
          end
        end
        StExec: begin
          if (cnt_q == '0) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_hi_q    <= err_pend_q ? '0 : alu_result[63:32];
            rsp_lo_q    <= err_pend_q ? '0 : alu_result[31:0];
            rsp_err_q   <= err_pend_q;
            rsp_dz_q    <= dz_pend_q;
            alu_op_q    <= OpNop;
            alu_incpc_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign alu_A      = alu_a_q;
  assign alu_B      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign alu_IncPC  = alu_incpc_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_hi     = rsp_hi_q;
  assign rsp_lo     = rsp_lo_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_dz     = rsp_dz_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: behavioural ALU plus a request-level reference model.
module tb_alu_sequencer;

  localparam int MulCyc = 2;
  localparam int DivCyc = 4;

  localparam logic [4:0] OP_AND = 5'b01010, OP_OR = 5'b01011, OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100, OP_MUL = 5'b01111, OP_DIV = 5'b10000;
  localparam logic [4:0] OP_SHR = 5'b00101, OP_SHRA = 5'b00110, OP_SHL = 5'b00111;
  localparam logic [4:0] OP_ROR = 5'b01000, OP_ROL = 5'b01001, OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010, OP_NOP = 5'b11010;

  logic [4:0] legal_ops [14] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHR,
                                 OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT, OP_NOP};

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [4:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_incpc = 1'b0;
  logic [31:0] alu_A, alu_B;
  logic [4:0]  alu_opcode;
  logic        alu_IncPC;
  logic [63:0] alu_result;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_hi, rsp_lo;
  logic        rsp_err, rsp_dz, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.MUL_CYCLES(MulCyc), .DIV_CYCLES(DivCyc)) dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_incpc(req_incpc), .alu_A(alu_A), .alu_B(alu_B),
    .alu_opcode(alu_opcode), .alu_IncPC(alu_IncPC), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_err(rsp_err), .rsp_dz(rsp_dz), .busy(busy)
  );

  // Behavioural stand-in for the external combinational ALU.
  function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic inc);
    logic [31:0] r;
    logic [4:0]  s;
    s = b[4:0];
    if (inc) return {32'h0, a + 32'd4};
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  return {32'h0, a} * {32'h0, b};
      OP_DIV:  return (b == 0) ? 64'hBAD0_0000_BAD0_0000 : {a % b, a / b};
      OP_SHR:  r = a >> s;
      OP_SHRA: r = $signed(a) >>> s;
      OP_SHL:  r = a << s;
      OP_ROR:  r = (a >> s) | (a << (6'd32 - {1'b0, s}));
      OP_ROL:  r = (a << s) | (a >> (6'd32 - {1'b0, s}));
      OP_NEG:  r = -a;
      OP_NOT:  r = ~a;
      OP_NOP:  return 64'hDEAD_BEEF_0000_0001;
      default: return 64'hDEAD_BEEF_0000_0002;
    endcase
    return {32'h0, r};
  endfunction

  assign alu_result = alu_model(alu_opcode, alu_A, alu_B, alu_IncPC);

  function automatic bit is_legal(input logic [4:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // One full transaction: accept, settle window, held response, release.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic inc, input int stall, input bit poke);
    bit          lg, bad, exp_err, exp_dz;
    int          exp_cyc, n;
    logic [4:0]  exp_drv;
    logic [63:0] exp_res;
    lg      = inc || is_legal(op);
    exp_err = !lg;
    exp_dz  = !inc && op == OP_DIV && b == 0;
    exp_cyc = (inc || !lg) ? 1 : (op == OP_MUL) ? MulCyc : (op == OP_DIV) ? DivCyc : 1;
    exp_drv = (inc || !lg) ? OP_NOP : op;
    exp_res = exp_err ? 64'h0 : alu_model(op, a, b, inc);

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_req op=%b: got %b want 1", op, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_incpc = inc;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0; bad = 0;
    while (rsp_valid !== 1'b1 && n < 64) begin
      if (alu_opcode !== exp_drv || alu_IncPC !== inc || alu_A !== a || alu_B !== b ||
          busy !== 1'b1 || req_ready !== 1'b0) bad = 1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != exp_cyc) begin
      errors++;
      $display("FAIL exec_cycles op=%b inc=%b: got %0d want %0d", op, inc, n, exp_cyc);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL exec_drive op=%b: got opc=%b inc=%b A=%h B=%h want opc=%b inc=%b A=%h B=%h",
               op, alu_opcode, alu_IncPC, alu_A, alu_B, exp_drv, inc, a, b);
    end
    for (int k = 0; k <= stall; k++) begin
      checks++;
      if ({rsp_hi, rsp_lo} !== exp_res || rsp_err !== exp_err || rsp_dz !== exp_dz ||
          rsp_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1 ||
          alu_opcode !== OP_NOP || alu_IncPC !== 1'b0 || alu_A !== a) begin
        errors++;
        $display("FAIL response op=%b cyc=%0d: got v=%b res=%h err=%b dz=%b rdy=%b opc=%b A=%h want v=1 res=%h err=%b dz=%b rdy=0 opc=%b A=%h",
                 op, k, rsp_valid, {rsp_hi, rsp_lo}, rsp_err, rsp_dz, req_ready, alu_opcode,
                 alu_A, exp_res, exp_err, exp_dz, OP_NOP, a);
      end
      if (k < stall) begin
        if (poke) begin
          req_valid = 1'b1; req_op = OP_ADD; req_a = ~a; req_b = ~b;
        end
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release op=%b: got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0",
               op, rsp_valid, req_ready, busy);
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || alu_opcode !== OP_NOP ||
        alu_IncPC !== 1'b0 || alu_A !== 32'h0 || alu_B !== 32'h0 || rsp_hi !== 32'h0 ||
        rsp_lo !== 32'h0 || rsp_err !== 1'b0 || rsp_dz !== 1'b0) begin
      errors++;
      $display("FAIL %s: got rdy=%b busy=%b v=%b opc=%b inc=%b A=%h B=%h res=%h err=%b dz=%b want rdy=1 opc=%b rest 0",
               tag, req_ready, busy, rsp_valid, alu_opcode, alu_IncPC, alu_A, alu_B,
               {rsp_hi, rsp_lo}, rsp_err, rsp_dz, OP_NOP);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset_state");
    clr = 1'b0;
  endtask

  task automatic test_add();
    run_op(OP_ADD, 32'd5, 32'd7, 1'b0, 0, 1'b0);
  endtask

  task automatic test_mul();
    run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0, 0, 1'b0);
  endtask

  task automatic test_div();
    run_op(OP_DIV, 32'd9, 32'd0, 1'b0, 0, 1'b0);
    run_op(OP_DIV, 32'd17, 32'd5, 1'b0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Requests offered while the response is held must be ignored.
    run_op(OP_SUB, 32'd3, 32'd5, 1'b0, 5, 1'b1);
    run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 0, 1'b0);
  endtask

  task automatic test_illegal_incpc();
    run_op(5'b11111, 32'd1, 32'd2, 1'b0, 0, 1'b0);
    run_op(OP_MUL, 32'h0000_0100, 32'd3, 1'b1, 0, 1'b0);
  endtask

  task automatic test_clr();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd100; req_b = 32'd7; req_incpc = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_reset_state("clr_mid_exec");
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL clr_dropped: got %0d active cycles want 0", seen);
    end
    // Reset and request on the same edge: reset wins.
    clr = 1'b1; req_valid = 1'b1; req_op = OP_ADD; req_a = 32'd1; req_b = 32'd1;
    @(negedge clk);
    clr = 1'b0; req_valid = 1'b0;
    check_reset_state("clr_with_req");
    // Reset while a response is pending.
    req_valid = 1'b1; req_op = OP_ADD; req_a = 32'd4; req_b = 32'd4;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_reset_state("clr_in_resp");
  endtask

  task automatic test_random();
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        inc;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) op = 5'($urandom);
      else op = legal_ops[$urandom_range(0, 13)];
      inc = ($urandom_range(0, 9) == 0);
      a   = $urandom;
      b   = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 1) == 0) b = b & 32'h0000_00FF;
      run_op(op, a, b, inc, $urandom_range(0, 2), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_back_to_back();
    test_illegal_incpc();
    test_clr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
